// File: rtl/rr_bus_arbiter6.sv
// rr_bus_arbiter6 - round-robin arbiter for one shared 32-bit resource port.
//
// Up to six requesters compete for the port. The registered grant index (SEL)
// drives the 3-bit select of the 6-to-1 mux in front of the resource, so only
// the owner's address/data reaches it. A grant is held until the resource
// reports DONE, the owner drops its request, or the hold limit expires.
//
// Ports:
//   CLK      in   system clock, all state changes on the rising edge
//   RST_N    in   synchronous active-low reset
//   REQ      in   [5:0] request levels; bits at index >= NUM_REQ are ignored
//   DONE     in   current transaction on the resource finishes this cycle
//   GNT      out  [5:0] one-hot grant (registered)
//   SEL      out  [2:0] binary owner index, 0 when idle (registered)
//   VALID    out  a grant is active (registered)
//   TIMEOUT  out  one-cycle pulse after a grant is revoked by the hold limit
module rr_bus_arbiter6 #(
    parameter int NUM_REQ  = 6,
    parameter int MAX_HOLD = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [5:0] REQ,
    input  logic       DONE,
    output logic [5:0] GNT,
    output logic [2:0] SEL,
    output logic       VALID,
    output logic       TIMEOUT
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam int              CW       = $clog2(MAX_HOLD + 1);
    localparam logic [6:0]      MASK_W   = (7'd1 << NUM_REQ) - 7'd1;
    localparam logic [5:0]      REQ_MASK = MASK_W[5:0];
    localparam logic [2:0]      LAST_IDX = 3'(NUM_REQ - 1);
    localparam logic [CW-1:0]   HOLD_MAX = CW'(MAX_HOLD);

    // Circular search from ptr upward, wrapping at NUM_REQ-1.
    // Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [5:0] req, input logic [2:0] ptr);
        logic [3:0] result;
        logic [3:0] idx;
        logic       found;
        result = 4'd0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end else begin
                idx = idx;
            end
            if (!found && req[idx[2:0]]) begin
                found  = 1'b1;
                result = {1'b1, idx[2:0]};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    state_t         state_r, state_n;
    logic [5:0]     gnt_r, gnt_n;
    logic [2:0]     sel_r, sel_n;
    logic           valid_r, valid_n;
    logic           timeout_r, timeout_n;
    logic [CW-1:0]  cnt_r, cnt_n;
    logic [2:0]     ptr_r, ptr_n;

    logic [5:0]     req_m_s;
    logic           owner_req_s;
    logic           at_limit_s;
    logic           release_s;
    logic [2:0]     nxt_ptr_s;
    logic [2:0]     arb_ptr_s;
    logic [3:0]     pick_s;

    // Release evaluation and arbitration; in OWN the search already uses the
    // post-release pointer so a new owner can be granted without a bubble.
    always_comb begin
        req_m_s     = REQ & REQ_MASK;
        owner_req_s = |(gnt_r & req_m_s);
        at_limit_s  = (cnt_r == HOLD_MAX);
        release_s   = DONE | ~owner_req_s | at_limit_s;
        if (sel_r >= LAST_IDX) begin
            nxt_ptr_s = 3'd0;
        end else begin
            nxt_ptr_s = sel_r + 3'd1;
        end
        if (state_r == ST_OWN) begin
            arb_ptr_s = nxt_ptr_s;
        end else begin
            arb_ptr_s = ptr_r;
        end
        pick_s = rr_pick(req_m_s, arb_ptr_s);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_r;
        gnt_n     = gnt_r;
        sel_n     = sel_r;
        valid_n   = valid_r;
        cnt_n     = cnt_r;
        ptr_n     = ptr_r;
        timeout_n = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[3]) begin
                    state_n = ST_OWN;
                    gnt_n   = 6'd1 << pick_s[2:0];
                    sel_n   = pick_s[2:0];
                    valid_n = 1'b1;
                    cnt_n   = CW'(1);
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (release_s) begin
                    ptr_n = nxt_ptr_s;
                    // Timeout only when the hold limit is the sole cause.
                    timeout_n = at_limit_s & ~DONE & owner_req_s;
                    if (pick_s[3]) begin
                        state_n = ST_OWN;
                        gnt_n   = 6'd1 << pick_s[2:0];
                        sel_n   = pick_s[2:0];
                        valid_n = 1'b1;
                        cnt_n   = CW'(1);
                    end else begin
                        state_n = ST_IDLE;
                        gnt_n   = 6'd0;
                        sel_n   = 3'd0;
                        valid_n = 1'b0;
                        cnt_n   = {CW{1'b0}};
                    end
                end else begin
                    if (at_limit_s) begin
                        cnt_n = cnt_r;
                    end else begin
                        cnt_n = cnt_r + CW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = 6'd0;
                sel_n   = 3'd0;
                valid_n = 1'b0;
                cnt_n   = {CW{1'b0}};
                ptr_n   = 3'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r   <= ST_IDLE;
            gnt_r     <= 6'd0;
            sel_r     <= 3'd0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            ptr_r     <= 3'd0;
        end else begin
            state_r   <= state_n;
            gnt_r     <= gnt_n;
            sel_r     <= sel_n;
            valid_r   <= valid_n;
            timeout_r <= timeout_n;
            cnt_r     <= cnt_n;
            ptr_r     <= ptr_n;
        end
    end

    assign GNT     = gnt_r;
    assign SEL     = sel_r;
    assign VALID   = valid_r;
    assign TIMEOUT = timeout_r;

endmodule

// File: doc/rr_bus_arbiter6.md
Name: rr_bus_arbiter6

Overview:
- Round-robin arbiter that shares one 32-bit shared-resource port (e.g. the memory/MMIO bus) among up to six requesters.
- Its registered grant index drives the 3-bit select of the OTTER 6-to-1 multiplexer feeding that port, so exactly one requester's address/data reaches the resource at a time.
- Grants are held until the resource signals transaction completion, the owner withdraws its request, or a hold-timeout expires.

Parameters:
- NUM_REQ, 6, number of active requesters (1..6); REQ bits at index >= NUM_REQ are ignored.
- MAX_HOLD, 16, maximum consecutive cycles one owner may keep the grant (2..255).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- REQ  input  6  per-requester request level; held high until the transaction completes.
- DONE  input  1  shared resource: current transaction finishes this cycle.
- GNT  output  6  one-hot grant, registered.
- SEL  output  3  binary index of the owner; drives the mux select (0..5).
- VALID  output  1  a grant is active (GNT != 0).
- TIMEOUT  output  1  one-cycle pulse when a grant is forcibly revoked by the hold limit.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - GNT=0, SEL=0, VALID=0, TIMEOUT=0, state=IDLE, hold count=0, priority pointer=0.
  - Reset applies even mid-grant; the owner loses the grant on that edge.
- States: IDLE, OWN.
- Arbitration function:
  - Search the masked REQ circularly starting at the pointer, ascending index, wrap from NUM_REQ-1 to 0.
  - The first set bit wins.
- IDLE:
  - If any masked REQ bit is set, the edge loads GNT/SEL with the winner, sets VALID=1, sets hold count=1 and moves to OWN.
  - Latency is one cycle from REQ high to GNT high.
  - DONE is ignored in IDLE.
- OWN release conditions, evaluated each cycle:
  - (a) DONE=1.
  - (b) REQ[SEL]=0.
  - (c) hold count==MAX_HOLD with DONE=0.
- OWN with no release: hold GNT/SEL and increment hold count.
- On release:
  - Pointer becomes (SEL+1) mod NUM_REQ.
  - Arbitration runs in the same cycle using the new pointer and the current REQ, including the old owner's bit.
  - If a winner exists, the next edge grants it with no bubble, hold count=1, state stays OWN. The old owner is regranted only if it is the sole requester.
  - If there is no winner, the next edge sets GNT=0, SEL=0, VALID=0 and state=IDLE.
- TIMEOUT:
  - Asserted for exactly the one cycle following a release caused only by condition (c).
  - DONE takes precedence: if DONE=1 and the count is at MAX_HOLD, there is no TIMEOUT.
- Invariants:
  - GNT is always zero or one-hot.
  - SEL equals the index of the GNT bit when VALID=1, and 0 otherwise.
  - GNT never changes except on a release edge or a reset edge.
- Hold counter: width clog2(MAX_HOLD+1); never wraps, saturates at MAX_HOLD.
- Edge-case rules:
  - REQ changes on non-owner bits during OWN have no effect until the next release.
  - If all REQ bits drop while in OWN, condition (b) releases to IDLE.

Test Plan:
- Single requester: after reset, REQ=6'b000100 → next cycle GNT=000100, SEL=2, VALID=1. DONE pulse → following cycle GNT=0, SEL=0, VALID=0.
- Round-robin fairness: REQ=6'b111111 held, DONE pulsed every 2nd cycle of ownership → SEL sequence 0,1,2,3,4,5,0 with back-to-back grants and no idle cycle.
- Pointer wrap with NUM_REQ=6: owner 5 releases with REQ=6'b100001 → next owner 0. Then 0 releases → next owner 5.
- Timeout: MAX_HOLD=4, REQ=6'b000011, DONE held 0 → GNT=000001 for exactly 4 cycles, TIMEOUT=1 for one cycle as GNT switches to 000010.
- DONE coincident with limit: count==MAX_HOLD and DONE=1 → release with TIMEOUT=0. Separately, owner drops REQ → release the next cycle.
- Reset mid-grant: SEL=3, VALID=1, RST_N=0 for one edge → GNT=0, SEL=0, VALID=0. With REQ=6'b001001 after reset → requester 0 granted first, since the pointer is 0.
